pipe_stall_ctrl: RTL and testbench

Pipeline control block that consumes the hazard unit's one-cycle stall pulse, the branch-taken flush request, the cache miss signals and the halt indication. It produces per-stage write enables, the bubble and flush controls, a sticky halted flag and a miss watchdog error. It sits beside the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and owns freeze and bubble arbitration. It also latches any stall or flush request that arrives while the pipeline is frozen, because the hazard unit never repeats a pulse.

---
 rtl/pipe_stall_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: freeze/bubble/flush arbitration for a five-stage pipeline.
// Consumes the hazard unit's stall pulse, branch flush requests, cache miss
// levels and the WB halt indication; produces per-stage write enables,
// bubble/flush controls, a sticky halted flag and a miss watchdog error.
// Stall/flush pulses arriving while the pipeline is frozen are held in
// pending latches because the hazard unit never repeats a pulse.
// Optional: define PIPE_STALL_PERF_EN to add saturating performance counters.
module pipe_stall_ctrl #(
  parameter int unsigned MISS_TIMEOUT = 255,
  parameter int unsigned TO_W         = 8
`ifdef PIPE_STALL_PERF_EN
  ,
  parameter int unsigned CNT_W        = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_req,
  input  logic             branch_taken,
  input  logic             icache_miss,
  input  logic             dcache_miss,
  input  logic             hlt_wb,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             halted,
  output logic             miss_err
`ifdef PIPE_STALL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_cycles,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_bubble,
  output logic [CNT_W-1:0] perf_flush
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IMISS = 2'd1,
    DMISS = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_eff;
  state_t          state_nxt;
  logic            pend_stall;
  logic            pend_flush;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_nxt;

  logic eff_stall;
  logic eff_flush;
  logic c_halt;
  logic c_dmiss;
  logic c_stall;
  logic c_imiss;
  logic c_flush;
  logic miss_hold;

  // Priority arbitration of the enables; while rst_n is low the registered
  // state and pending latches are masked so the reset cycle sees RUN defaults.
  always_comb begin
    state_eff = rst_n ? state : RUN;
    eff_stall = stall_req    | (pend_stall & rst_n);
    eff_flush = branch_taken | (pend_flush & rst_n);

    c_halt  = (state_eff == HALT) | hlt_wb;
    c_dmiss = ~c_halt & dcache_miss;
    c_stall = ~c_halt & ~c_dmiss & eff_stall;
    c_imiss = ~c_halt & ~c_dmiss & ~eff_stall & icache_miss;
    c_flush = ~c_halt & ~c_dmiss & ~eff_stall & ~icache_miss & eff_flush;

    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_we    = 1'b1;
    mem_wb_we    = 1'b1;

    if (c_halt || c_dmiss) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      ex_mem_we = 1'b0;
      mem_wb_we = 1'b0;
    end else if (c_stall) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (c_imiss) begin
      pc_we       = 1'b0;
      if_id_flush = 1'b1;
    end else if (c_flush) begin
      if_id_flush = 1'b1;
    end
  end

  // Next state and saturating watchdog count.
  always_comb begin
    if (hlt_wb || state == HALT) begin
      state_nxt = HALT;
    end else if (dcache_miss) begin
      state_nxt = DMISS;
    end else if (icache_miss) begin
      state_nxt = IMISS;
    end else begin
      state_nxt = RUN;
    end

    miss_hold = ((state == IMISS) && icache_miss) ||
                ((state == DMISS) && dcache_miss);
    if (!miss_hold) begin
      to_cnt_nxt = '0;
    end else if (to_cnt == '1) begin
      to_cnt_nxt = to_cnt;
    end else begin
      to_cnt_nxt = to_cnt + 1'b1;
    end
  end

  // State, pending request latches, watchdog counter and sticky error.
  // miss_err is set on the same edge that loads to_cnt with MISS_TIMEOUT so
  // the flag is visible together with the matching count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      pend_stall <= 1'b0;
      pend_flush <= 1'b0;
      to_cnt     <= '0;
      miss_err   <= 1'b0;
    end else begin
      state  <= state_nxt;
      to_cnt <= to_cnt_nxt;
      if (to_cnt_nxt == TO_W'(MISS_TIMEOUT)) begin
        miss_err <= 1'b1;
      end

      if (c_stall) begin
        pend_stall <= 1'b0;
      end else if (stall_req && (c_halt || c_dmiss)) begin
        pend_stall <= 1'b1;
      end

      if (c_imiss || c_flush) begin
        pend_flush <= 1'b0;
      end else if (branch_taken && (c_halt || c_dmiss || c_stall)) begin
        pend_flush <= 1'b1;
      end
    end
  end

  assign halted = (state == HALT);

`ifdef PIPE_STALL_PERF_EN
  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
      perf_bubble <= '0;
      perf_flush  <= '0;
    end else begin
      if (state != HALT && perf_cycles != '1) begin
        perf_cycles <= perf_cycles + 1'b1;
      end
      if (state != HALT && !pc_we && perf_stall != '1) begin
        perf_stall <= perf_stall + 1'b1;
      end
      if (id_ex_bubble && perf_bubble != '1) begin
        perf_bubble <= perf_bubble + 1'b1;
      end
      if (if_id_flush && perf_flush != '1) begin
        perf_flush <= perf_flush + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed self-checking bench for pipe_stall_ctrl.
// Inputs change just after the falling edge; outputs are sampled 2 time units
// later, well before the next rising edge.
module tb_pipe_stall_ctrl;

  // Enable vector {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we}
  localparam logic [5:0] RUNV = 6'b110011;
  localparam logic [5:0] FRZ  = 6'b000000;
  localparam logic [5:0] BUB  = 6'b000111;
  localparam logic [5:0] IMS  = 6'b011011;
  localparam logic [5:0] FLS  = 6'b111011;

  // Stimulus vector {stall_req, branch_taken, icache_miss, dcache_miss, hlt_wb}
  localparam logic [4:0] I_NONE = 5'b00000;
  localparam logic [4:0] I_ST   = 5'b10000;
  localparam logic [4:0] I_BR   = 5'b01000;
  localparam logic [4:0] I_IC   = 5'b00100;
  localparam logic [4:0] I_DC   = 5'b00010;
  localparam logic [4:0] I_HLT  = 5'b00001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall_req = 1'b0;
  logic branch_taken = 1'b0;
  logic icache_miss = 1'b0;
  logic dcache_miss = 1'b0;
  logic hlt_wb = 1'b0;
  logic pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we;
  logic halted, miss_err;
  logic [5:0] en;

  int n_checks = 0;
  int n_fails  = 0;

  assign en = {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we};

  pipe_stall_ctrl #(
    .MISS_TIMEOUT(4),
    .TO_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall_req(stall_req),
    .branch_taken(branch_taken),
    .icache_miss(icache_miss),
    .dcache_miss(dcache_miss),
    .hlt_wb(hlt_wb),
    .pc_we(pc_we),
    .if_id_we(if_id_we),
    .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble),
    .ex_mem_we(ex_mem_we),
    .mem_wb_we(mem_wb_we),
    .halted(halted),
    .miss_err(miss_err)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus and settle before sampling.
  task automatic drive(input logic [4:0] v);
    @(negedge clk);
    {stall_req, branch_taken, icache_miss, dcache_miss, hlt_wb} = v;
    #2;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    {stall_req, branch_taken, icache_miss, dcache_miss, hlt_wb} = I_NONE;
    #2;
    n_checks++;
    if (en !== RUNV) begin
      n_fails++;
      $display("FAIL reset_enables: got %b expected %b", en, RUNV);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    n_checks++;
    if ({halted, miss_err} !== 2'b00) begin
      n_fails++;
      $display("FAIL reset_flags: got halted=%b miss_err=%b expected 0 0", halted, miss_err);
    end
    n_checks++;
    if (en !== RUNV) begin
      n_fails++;
      $display("FAIL post_reset_enables: got %b expected %b", en, RUNV);
    end
  endtask

  task automatic test_load_use;
    logic [4:0] stim [2];
    logic [5:0] exp  [2];
    stim = '{I_ST, I_NONE};
    exp  = '{BUB, RUNV};
    for (int i = 0; i < 2; i++) begin
      drive(stim[i]);
      n_checks++;
      if (en !== exp[i]) begin
        n_fails++;
        $display("FAIL load_use[%0d]: got %b expected %b", i, en, exp[i]);
      end
    end
  endtask

  task automatic test_deferred_stall;
    logic [4:0] stim [6];
    logic [5:0] exp  [6];
    stim = '{I_DC, I_DC | I_ST, I_DC, I_DC, I_NONE, I_NONE};
    exp  = '{FRZ, FRZ, FRZ, FRZ, BUB, RUNV};
    for (int i = 0; i < 6; i++) begin
      drive(stim[i]);
      n_checks++;
      if (en !== exp[i]) begin
        n_fails++;
        $display("FAIL deferred_stall[%0d]: got %b expected %b", i, en, exp[i]);
      end
    end
    n_checks++;
    if (miss_err !== 1'b0) begin
      n_fails++;
      $display("FAIL deferred_no_err: got miss_err=%b expected 0", miss_err);
    end
  endtask

  task automatic test_stall_branch;
    logic [4:0] stim [4];
    logic [5:0] exp  [4];
    stim = '{I_ST | I_BR, I_NONE, I_NONE, I_BR};
    exp  = '{BUB, FLS, RUNV, FLS};
    for (int i = 0; i < 4; i++) begin
      drive(stim[i]);
      n_checks++;
      if (en !== exp[i]) begin
        n_fails++;
        $display("FAIL stall_branch[%0d]: got %b expected %b", i, en, exp[i]);
      end
    end
  endtask

  task automatic test_imiss;
    logic [4:0] stim [5];
    logic [5:0] exp  [5];
    stim = '{I_IC, I_IC, I_IC, I_NONE, I_NONE};
    exp  = '{IMS, IMS, IMS, RUNV, RUNV};
    for (int i = 0; i < 5; i++) begin
      drive(stim[i]);
      n_checks++;
      if (en !== exp[i]) begin
        n_fails++;
        $display("FAIL imiss[%0d]: got %b expected %b", i, en, exp[i]);
      end
    end
  endtask

  task automatic test_priority;
    logic [4:0] stim [6];
    logic [5:0] exp  [6];
    // frozen branch is held, an I-miss consumes it, stall beats I-miss,
    // I-miss beats a fresh branch and consumes it too
    stim = '{I_DC | I_IC | I_BR, I_IC, I_ST | I_IC, I_NONE, I_BR | I_IC, I_NONE};
    exp  = '{FRZ, IMS, BUB, RUNV, IMS, RUNV};
    for (int i = 0; i < 6; i++) begin
      drive(stim[i]);
      n_checks++;
      if (en !== exp[i]) begin
        n_fails++;
        $display("FAIL priority[%0d]: got %b expected %b", i, en, exp[i]);
      end
    end
  endtask

  task automatic test_watchdog;
    for (int i = 0; i < 10; i++) begin
      drive(I_DC);
      n_checks++;
      if ({en, miss_err} !== {FRZ, (i >= 5)}) begin
        n_fails++;
        $display("FAIL watchdog[%0d]: got en=%b miss_err=%b expected en=%b miss_err=%b",
                 i, en, miss_err, FRZ, (i >= 5));
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(I_NONE);
      n_checks++;
      if ({en, miss_err} !== {RUNV, 1'b1}) begin
        n_fails++;
        $display("FAIL watchdog_sticky[%0d]: got en=%b miss_err=%b expected en=%b miss_err=1",
                 i, en, miss_err, RUNV);
      end
    end
    test_reset();
    n_checks++;
    if (miss_err !== 1'b0) begin
      n_fails++;
      $display("FAIL watchdog_clear: got miss_err=%b expected 0", miss_err);
    end
  endtask

  task automatic test_halt;
    logic [4:0] stim [10];
    logic [5:0] exp  [10];
    logic       hexp [10];
    stim = '{I_NONE, I_NONE, I_NONE, I_NONE, I_NONE,
             I_HLT | I_DC, I_NONE, I_ST, I_BR, I_NONE};
    exp  = '{RUNV, RUNV, RUNV, RUNV, RUNV, FRZ, FRZ, FRZ, FRZ, FRZ};
    hexp = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 10; i++) begin
      drive(stim[i]);
      n_checks++;
      if ({en, halted} !== {exp[i], hexp[i]}) begin
        n_fails++;
        $display("FAIL halt[%0d]: got en=%b halted=%b expected en=%b halted=%b",
                 i, en, halted, exp[i], hexp[i]);
      end
    end
    // reset from HALT with pending stall/flush latched: both discarded
    test_reset();
    drive(I_NONE);
    n_checks++;
    if ({en, halted} !== {RUNV, 1'b0}) begin
      n_fails++;
      $display("FAIL halt_release: got en=%b halted=%b expected en=%b halted=0", en, halted, RUNV);
    end
  endtask

  task automatic test_reset_mid_freeze;
    drive(I_DC | I_ST | I_BR);
    n_checks++;
    if (en !== FRZ) begin
      n_fails++;
      $display("FAIL mid_freeze: got %b expected %b", en, FRZ);
    end
    test_reset();
    drive(I_NONE);
    n_checks++;
    if (en !== RUNV) begin
      n_fails++;
      $display("FAIL mid_freeze_discard: got %b expected %b", en, RUNV);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_deferred_stall();
    test_stall_branch();
    test_imiss();
    test_priority();
    test_watchdog();
    test_halt();
    test_reset_mid_freeze();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
